// File: rtl/mtm_alu_pkg.sv
// Shared mtm_Alu definitions: frame constants, error codes, flag indices,
// serializer FSM encoding, and the CRC helpers used by both the
// deserializer (CRC4) and the serializer (CRC3).
package mtm_alu_pkg;

    localparam int unsigned FRAME_LEN = 11;
    localparam logic        TYPE_DATA = 1'b0;
    localparam logic        TYPE_CTL  = 1'b1;

    localparam logic [5:0] ERR_DATA = 6'b100100;
    localparam logic [5:0] ERR_CRC  = 6'b010010;
    localparam logic [5:0] ERR_OP   = 6'b001001;

    localparam int unsigned FLAG_CARRY    = 3;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_ZERO     = 1;
    localparam int unsigned FLAG_NEGATIVE = 0;

    // x^3 + x + 1, leading term implicit
    localparam int unsigned CRC3_MSG_W = 37;
    localparam logic [2:0]  CRC3_POLY  = 3'b011;

    // x^4 + x + 1, leading term implicit
    localparam int unsigned CRC4_MSG_W = 68;
    localparam logic [3:0]  CRC4_POLY  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } ser_state_e;

    // One captured core transaction
    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  flags;
        logic [5:0]  err;
    } ser_req_t;

    // Serial CRC3, MSB first, init 000
    function automatic logic [2:0] crc3_37(input logic [CRC3_MSG_W-1:0] msg);
        logic [2:0] crc;
        logic       fb;
        crc = '0;
        for (int i = int'(CRC3_MSG_W) - 1; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
        end
        return crc;
    endfunction

    // Serial CRC4, MSB first, init 0000 (deserializer side)
    function automatic logic [3:0] crc4_68(input logic [CRC4_MSG_W-1:0] msg);
        logic [3:0] crc;
        logic       fb;
        crc = '0;
        for (int i = int'(CRC4_MSG_W) - 1; i >= 0; i--) begin
            fb  = crc[3] ^ msg[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
        end
        return crc;
    endfunction

    // start 0, type, payload MSB first, stop 1
    function automatic logic [FRAME_LEN-1:0] make_frame(input logic       typ,
                                                        input logic [7:0] payload);
        return {1'b0, typ, payload, 1'b1};
    endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 over the 37-bit {C, 1'b0, flags} message.
module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  logic [CRC3_MSG_W-1:0] msg,
    output logic [2:0]            crc_c
);

    // Pure function of the captured result; evaluated during LOAD
    always_comb begin
        crc_c = crc3_37(msg);
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_Alu output stage: frames one result or error code into 11-bit frames
// and shifts them out MSB first on sout, one bit per clock.
// Optional macro MTM_ALU_SER_PARITY_EN: error-frame bit0 carries even parity
// over {1'b1, err}; when undefined that bit is 0.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned DATA_FRAMES = 4,
    parameter int unsigned IDLE_GAP    = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] C_in,
    input  logic [3:0]  flags_in,
    input  logic [5:0]  err_in,
    output logic        busy,
    output logic        done,
    output logic        sout
);

    localparam int unsigned NUM_FRAMES = DATA_FRAMES + 1;
    localparam int unsigned BUF_W      = NUM_FRAMES * FRAME_LEN;
    localparam int unsigned FCNT_W     = $clog2(NUM_FRAMES + 1);
    localparam int unsigned GAP_W      = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int unsigned GAP_LAST   = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
    localparam logic [3:0]  BIT_LAST   = 4'(FRAME_LEN - 1);

    ser_state_e        state_q, state_d;
    ser_req_t          req_q, req_d;
    logic [BUF_W-1:0]  frame_buf_q, frame_buf_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FCNT_W-1:0] num_frames_q, num_frames_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              sout_d, busy_d, done_d;

    logic [2:0]        crc_c;
    logic              par_c;
    logic              send_end_c;
    logic              gap_end_c;
    logic [BUF_W-1:0]  data_buf_c;
    logic [BUF_W-1:0]  err_buf_c;

    mtm_alu_crc3 u_crc3 (
        .msg   ({req_q.c, 1'b0, req_q.flags}),
        .crc_c (crc_c)
    );

    // Error-frame check bit
    always_comb begin
`ifdef MTM_ALU_SER_PARITY_EN
        par_c = ^{1'b1, req_q.err};
`else
        par_c = 1'b0;
`endif
    end

    // Packet images, left-aligned so the first bit sits at the MSB
    always_comb begin
        data_buf_c = '1;
        for (int k = 0; k < int'(DATA_FRAMES); k++) begin
            data_buf_c = {data_buf_c[BUF_W-FRAME_LEN-1:0],
                          make_frame(TYPE_DATA, 8'(req_q.c >> (8 * (3 - k))))};
        end
        data_buf_c = {data_buf_c[BUF_W-FRAME_LEN-1:0],
                      make_frame(TYPE_CTL, {1'b0,
                                            req_q.flags[FLAG_CARRY],
                                            req_q.flags[FLAG_OVERFLOW],
                                            req_q.flags[FLAG_ZERO],
                                            req_q.flags[FLAG_NEGATIVE],
                                            crc_c})};
        err_buf_c  = {make_frame(TYPE_CTL, {1'b1, req_q.err, par_c}),
                      {(BUF_W - FRAME_LEN){1'b1}}};
    end

    // Frame counter passes the last frame only after its stop bit is out
    always_comb begin
        send_end_c = (frame_cnt_q == num_frames_q);
        gap_end_c  = (gap_cnt_q == GAP_W'(GAP_LAST));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (valid_in)   state_d = ST_LOAD;
            ST_LOAD:                 state_d = ST_SEND;
            ST_SEND: if (send_end_c) state_d = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_end_c)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; busy also covers the forced gap
    always_comb begin
        sout_d       = 1'b1;
        done_d       = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        req_d        = req_q;
        frame_buf_d  = frame_buf_q;
        bit_cnt_d    = bit_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        num_frames_d = num_frames_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    req_d.c     = C_in;
                    req_d.flags = flags_in;
                    req_d.err   = err_in;
                end
            end
            ST_LOAD: begin
                bit_cnt_d   = '0;
                frame_cnt_d = '0;
                gap_cnt_d   = '0;
                if (req_q.err != '0) begin
                    frame_buf_d  = err_buf_c;
                    num_frames_d = FCNT_W'(1);
                end else begin
                    frame_buf_d  = data_buf_c;
                    num_frames_d = FCNT_W'(NUM_FRAMES);
                end
            end
            ST_SEND: begin
                if (send_end_c) begin
                    done_d = 1'b1;
                end else begin
                    sout_d      = frame_buf_q[BUF_W-1];
                    frame_buf_d = {frame_buf_q[BUF_W-2:0], 1'b1};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    end else begin
                        bit_cnt_d   = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs; reset forces the line idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sout         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_q        <= '0;
            frame_buf_q  <= '1;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            num_frames_q <= '0;
            gap_cnt_q    <= '0;
        end else begin
            sout         <= sout_d;
            busy         <= busy_d;
            done         <= done_d;
            req_q        <= req_d;
            frame_buf_q  <= frame_buf_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            num_frames_q <= num_frames_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed self-checking bench for mtm_alu_serializer (default parameters).
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] C_in;
    logic [3:0]  flags_in;
    logic [5:0]  err_in;
    logic        busy;
    logic        done;
    logic        sout;

    int n_err    = 0;
    int n_checks = 0;

`ifdef MTM_ALU_SER_PARITY_EN
    localparam logic [10:0] ERR_DATA_FRAME = 11'b01110010011;
    localparam logic [10:0] ERR_OP_FRAME   = 11'b01100100111;
`else
    localparam logic [10:0] ERR_DATA_FRAME = 11'b01110010001;
    localparam logic [10:0] ERR_OP_FRAME   = 11'b01100100101;
`endif

    // C=0, flags=0010: four zero data frames, then ctl payload 00010110
    localparam logic [54:0] ZERO_FLAG_STREAM = {11'b00000000001, 11'b00000000001,
                                                11'b00000000001, 11'b00000000001,
                                                11'b01000101101};

    mtm_alu_serializer #(.DATA_FRAMES(4), .IDLE_GAP(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .C_in     (C_in),
        .flags_in (flags_in),
        .err_in   (err_in),
        .busy     (busy),
        .done     (done),
        .sout     (sout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Remainder of {C,0,flags}*x^3 divided by x^3+x+1
    function automatic logic [2:0] crc3_model(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] v;
        v = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        end
        return v[2:0];
    endfunction

    function automatic logic [63:0] data_stream(input logic [31:0] c, input logic [3:0] f);
        logic [2:0] r;
        r = crc3_model(c, f);
        return 64'({2'b00, c[31:24], 1'b1, 2'b00, c[23:16], 1'b1,
                    2'b00, c[15:8],  1'b1, 2'b00, c[7:0],   1'b1,
                    2'b01, 1'b0, f, r, 1'b1});
    endfunction

    task automatic drive(input logic [31:0] c, input logic [3:0] f, input logic [5:0] e);
        @(negedge clk);
        valid_in = 1'b1;
        C_in     = c;
        flags_in = f;
        err_in   = e;
    endtask

    // Called at the negedge where the request is presented; returns at the done sample
    task automatic expect_packet(input string tag, input logic [63:0] exp, input int nbits,
                                 input bit release_valid, input int pulse_at);
        logic [63:0] stream;
        logic [1:0]  lead;
        bit          busy_bad;
        bit          done_bad;
        stream   = '0;
        lead     = '0;
        busy_bad = 1'b0;
        done_bad = 1'b0;
        for (int i = 1; i <= nbits + 3; i++) begin
            @(negedge clk);
            if (i == 1 && release_valid) valid_in = 1'b0;
            if (pulse_at >= 0 && i == pulse_at + 3) begin
                valid_in = 1'b1;
                C_in     = 32'h12345678;
                flags_in = 4'hF;
                err_in   = 6'd0;
            end
            if (pulse_at >= 0 && i == pulse_at + 4) valid_in = 1'b0;
            if (i <= 2) lead = {lead[0], sout};
            if (i <= nbits + 2) begin
                if (!busy) busy_bad = 1'b1;
                if (done)  done_bad = 1'b1;
            end
            if (i >= 3 && i <= nbits + 2) stream = {stream[62:0], sout};
        end
        check({tag, " lead idle"},     64'(lead),           64'h3);
        check({tag, " stream"},        stream,              exp);
        check({tag, " busy held"},     64'(busy_bad),       64'h0);
        check({tag, " no early done"}, 64'(done_bad),       64'h0);
        check({tag, " done/busy end"}, 64'({done, busy}),   64'h2);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!sout || busy || done) bad = 1'b1;
        end
        check(tag, 64'(bad), 64'h0);
    endtask

    initial begin
        logic [63:0] mid_exp;

        // Reset held with valid_in asserted
        rst      = 1'b0;
        valid_in = 1'b1;
        C_in     = 32'h0;
        flags_in = 4'h0;
        err_in   = 6'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset outputs", 64'({sout, busy, done}), 64'h4);
        end
        rst      = 1'b1;
        valid_in = 1'b0;
        expect_quiet("post-reset idle", 4);

        // Zero-flag result, hand-computed frames
        drive(32'h0, 4'b0010, 6'd0);
        expect_packet("zero flag", 64'(ZERO_FLAG_STREAM), 55, 1'b1, -1);

        // Error packets take priority over data
        drive(32'hFFFFFFFF, 4'hF, 6'b100100);
        expect_packet("err data", 64'(ERR_DATA_FRAME), 11, 1'b1, -1);
        drive(32'h12345678, 4'hF, 6'b001001);
        expect_packet("err op", 64'(ERR_OP_FRAME), 11, 1'b1, -1);

        // Second request while busy is dropped
        drive(32'hDEADBEEF, 4'b1001, 6'd0);
        expect_packet("busy drop", data_stream(32'hDEADBEEF, 4'b1001), 55, 1'b1, 10);
        expect_quiet("busy drop no second packet", 12);

        // Back-to-back with valid_in held; next start 3 samples after done
        drive(32'h01020304, 4'b0000, 6'd0);
        expect_packet("b2b first", data_stream(32'h01020304, 4'b0000), 55, 1'b0, -1);
        C_in     = 32'hA5A5A5A5;
        flags_in = 4'b0100;
        expect_packet("b2b second", data_stream(32'hA5A5A5A5, 4'b0100), 55, 1'b1, -1);

        // Reset at bit 20 of a data packet
        mid_exp = data_stream(32'h12345678, 4'b0001);
        drive(32'h12345678, 4'b0001, 6'd0);
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            if (i == 1) valid_in = 1'b0;
        end
        check("mid bit20 value", 64'(sout), 64'(mid_exp[34]));
        rst = 1'b0;
        #1;
        check("mid reset immediate", 64'({sout, busy, done}), 64'h4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("mid reset no done", 60);
        drive(32'h80000001, 4'b1000, 6'd0);
        expect_packet("after reset", data_stream(32'h80000001, 4'b1000), 55, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
